// File: rtl/fft_sdf_stage.sv
// rtl/fft_sdf_stage.sv - single-delay-feedback radix-2 FFT butterfly stage over LANES parallel samples
//
// Optional feature macro: FFT_SDF_STAGE_SAT_EN
//   defined   : sums/differences clamp to the IN_W range, clamps set sticky ovf_flag
//   undefined : full-precision OUT_W results, ovf_flag stays 0
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   din_valid   input beat qualifier
//   din_ready   stage accepts a beat this cycle (low only while draining)
//   din_r/din_i LANES x IN_W signed input real/imag, lane l at [l*IN_W +: IN_W]
//   dout_valid  output beat qualifier
//   dout_r/i    LANES x OUT_W signed output real/imag, lane l at [l*OUT_W +: OUT_W]
//   ovf_flag    sticky saturation indicator
module fft_sdf_stage #(
    parameter int IN_W  = 12,
    parameter int LANES = 16,
    parameter int DEPTH = 2,
    parameter int OUT_W = IN_W + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [LANES*IN_W-1:0]    din_r,
    input  logic [LANES*IN_W-1:0]    din_i,
    output logic                     dout_valid,
    output logic [LANES*OUT_W-1:0]   dout_r,
    output logic [LANES*OUT_W-1:0]   dout_i,
    output logic                     ovf_flag
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // S_ANEXT is the cycle right after the last b-beat: a valid beat there
    // starts the next a-half without a bubble, otherwise it is the first
    // drain emission.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BFLY  = 3'd2,
        S_ANEXT = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pend, pend_nxt;

    logic            accept;
    logic            cnt_last;
    logic [CW-1:0]   cnt_inc;

    logic [LANES*OUT_W-1:0] mem_r [DEPTH];
    logic [LANES*OUT_W-1:0] mem_i [DEPTH];
    logic [LANES*OUT_W-1:0] rd_r, rd_i;
    logic [LANES*OUT_W-1:0] ext_r, ext_i;
    logic [LANES*OUT_W-1:0] sum_r, sum_i, dif_r, dif_i;
    logic [LANES-1:0]       lane_clip;

    logic                   we;
    logic [LANES*OUT_W-1:0] wr_r, wr_i;
    logic                   ready_nxt, valid_nxt, ovf_nxt;
    logic [LANES*OUT_W-1:0] out_r_nxt, out_i_nxt;

    assign accept   = din_valid & din_ready;
    assign cnt_last = (cnt == CW'(DEPTH - 1));
    assign cnt_inc  = cnt_last ? '0 : cnt + CW'(1);
    assign rd_r     = mem_r[cnt];
    assign rd_i     = mem_i[cnt];

`ifdef FFT_SDF_STAGE_SAT_EN
    localparam logic signed [OUT_W-1:0] SMAX = OUT_W'((1 << (IN_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] SMIN = ~SMAX;

    function automatic logic is_clip(input logic signed [OUT_W-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic [OUT_W-1:0] clampv(input logic signed [OUT_W-1:0] v);
        if (v > SMAX)
            return SMAX;
        else if (v < SMIN)
            return SMIN;
        else
            return v;
    endfunction
`endif

    // Per-lane butterfly. a is always an IN_W value sign-extended into
    // OUT_W, so a+b and a-b are exact at OUT_W and the clamp test is exact.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [OUT_W-1:0] a_r, a_i, b_r, b_i, s_r, s_i, d_r, d_i;

        assign a_r = rd_r[l*OUT_W +: OUT_W];
        assign a_i = rd_i[l*OUT_W +: OUT_W];
        assign b_r = {{(OUT_W-IN_W){din_r[l*IN_W+IN_W-1]}}, din_r[l*IN_W +: IN_W]};
        assign b_i = {{(OUT_W-IN_W){din_i[l*IN_W+IN_W-1]}}, din_i[l*IN_W +: IN_W]};
        assign s_r = a_r + b_r;
        assign s_i = a_i + b_i;
        assign d_r = a_r - b_r;
        assign d_i = a_i - b_i;

        assign ext_r[l*OUT_W +: OUT_W] = b_r;
        assign ext_i[l*OUT_W +: OUT_W] = b_i;

`ifdef FFT_SDF_STAGE_SAT_EN
        assign sum_r[l*OUT_W +: OUT_W] = clampv(s_r);
        assign sum_i[l*OUT_W +: OUT_W] = clampv(s_i);
        assign dif_r[l*OUT_W +: OUT_W] = clampv(d_r);
        assign dif_i[l*OUT_W +: OUT_W] = clampv(d_i);
        assign lane_clip[l] = is_clip(s_r) | is_clip(s_i) | is_clip(d_r) | is_clip(d_i);
`else
        assign sum_r[l*OUT_W +: OUT_W] = s_r;
        assign sum_i[l*OUT_W +: OUT_W] = s_i;
        assign dif_r[l*OUT_W +: OUT_W] = d_r;
        assign dif_i[l*OUT_W +: OUT_W] = d_i;
        assign lane_clip[l] = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = (DEPTH == 1) ? S_BFLY : S_FILL;
                end
            end
            S_FILL, S_ANEXT: begin
                if (accept) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_last) begin
                        state_nxt = S_BFLY;
                        pend_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_FILL;
                    end
                end else if (state == S_ANEXT) begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = S_DRAIN;
                end
            end
            S_BFLY: begin
                if (accept) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_last) begin
                        state_nxt = S_ANEXT;
                        pend_nxt  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Entered with cnt=1 (mod DEPTH); wrapping back to 0 means
                // every difference has been emitted.
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    pend_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // Output / datapath decode
    always_comb begin
        we        = 1'b0;
        wr_r      = ext_r;
        wr_i      = ext_i;
        valid_nxt = 1'b0;
        out_r_nxt = dout_r;
        out_i_nxt = dout_i;
        ovf_nxt   = ovf_flag;
        case (state)
            S_IDLE: begin
                we = accept;
            end
            S_FILL, S_ANEXT: begin
                if (accept) begin
                    we        = 1'b1;
                    valid_nxt = pend;
                    out_r_nxt = rd_r;
                    out_i_nxt = rd_i;
                end else if (state == S_ANEXT) begin
                    valid_nxt = 1'b1;
                    out_r_nxt = rd_r;
                    out_i_nxt = rd_i;
                end
            end
            S_BFLY: begin
                if (accept) begin
                    we        = 1'b1;
                    wr_r      = dif_r;
                    wr_i      = dif_i;
                    valid_nxt = 1'b1;
                    out_r_nxt = sum_r;
                    out_i_nxt = sum_i;
                    ovf_nxt   = ovf_flag | (|lane_clip);
                end
            end
            S_DRAIN: begin
                if (cnt != '0) begin
                    valid_nxt = 1'b1;
                    out_r_nxt = rd_r;
                    out_i_nxt = rd_i;
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
        ready_nxt = (state_nxt != S_DRAIN);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_ready  <= 1'b1;
            dout_valid <= 1'b0;
            dout_r     <= '0;
            dout_i     <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            din_ready  <= ready_nxt;
            dout_valid <= valid_nxt;
            dout_r     <= out_r_nxt;
            dout_i     <= out_i_nxt;
            ovf_flag   <= ovf_nxt;
        end
    end

    // Delay storage; never read before written, so no reset needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[cnt] <= wr_r;
            mem_i[cnt] <= wr_i;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb/tb_fft_sdf_stage.sv - directed self-checking bench for fft_sdf_stage
module tb_fft_sdf_stage;

    localparam int IN_W  = 12;
    localparam int LANES = 16;
    localparam int DEPTH = 2;
    localparam int OUT_W = IN_W + 1;

`ifdef FFT_SDF_STAGE_SAT_EN
    localparam int BIG_R = 2047;
    localparam int BIG_I = -2048;
    localparam int BIG_O = 1;
`else
    localparam int BIG_R = 4094;
    localparam int BIG_I = -4096;
    localparam int BIG_O = 0;
`endif

    logic                   clk;
    logic                   rstn;
    logic                   din_valid;
    logic                   din_ready;
    logic [LANES*IN_W-1:0]  din_r, din_i;
    logic                   dout_valid;
    logic [LANES*OUT_W-1:0] dout_r, dout_i;
    logic                   ovf_flag;

    int total = 0;
    int bad   = 0;

    fft_sdf_stage #(
        .IN_W (IN_W),
        .LANES(LANES),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_r     (din_r),
        .din_i     (din_i),
        .dout_valid(dout_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .ovf_flag  (ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LANES*IN_W-1:0] rep_in(input int x);
        logic [IN_W-1:0]       t;
        logic [LANES*IN_W-1:0] v;
        t = x[IN_W-1:0];
        for (int l = 0; l < LANES; l++) v[l*IN_W +: IN_W] = t;
        return v;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] rep_out(input int x);
        logic [OUT_W-1:0]       t;
        logic [LANES*OUT_W-1:0] v;
        t = x[OUT_W-1:0];
        for (int l = 0; l < LANES; l++) v[l*OUT_W +: OUT_W] = t;
        return v;
    endfunction

    task automatic drive(input logic v, input int r, input int i);
        din_valid = v;
        din_r     = rep_in(r);
        din_i     = rep_in(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LANES*OUT_W-1:0] obs,
                       input logic [LANES*OUT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one output cycle: valid flag, and data when a beat is expected.
    task automatic out_is(input string tag, input logic v, input int r, input int i);
        chk({tag, ".valid"}, {{(LANES*OUT_W-1){1'b0}}, dout_valid}, {{(LANES*OUT_W-1){1'b0}}, v});
        if (v) begin
            chk({tag, ".r"}, dout_r, rep_out(r));
            chk({tag, ".i"}, dout_i, rep_out(i));
        end
    endtask

    task automatic ready_is(input string tag, input logic v);
        chk({tag, ".ready"}, {{(LANES*OUT_W-1){1'b0}}, din_ready}, {{(LANES*OUT_W-1){1'b0}}, v});
    endtask

    task automatic ovf_is(input string tag, input logic v);
        chk({tag, ".ovf"}, {{(LANES*OUT_W-1){1'b0}}, ovf_flag}, {{(LANES*OUT_W-1){1'b0}}, v});
    endtask

    // a=100,200 b=50,-300 then idle: sums 150,-100, diffs 50,500.
    task automatic basic_block(input string tag);
        drive(1, 100, 0);  tick(); out_is({tag, ".c1"}, 0, 0, 0);
        drive(1, 200, 0);  tick(); out_is({tag, ".c2"}, 0, 0, 0);
        drive(1, 50, 0);   tick(); out_is({tag, ".c3"}, 1, 150, 0);
        drive(1, -300, 0); tick(); out_is({tag, ".c4"}, 1, -100, 0); ready_is({tag, ".c4"}, 1);
        drive(0, 0, 0);    tick(); out_is({tag, ".c5"}, 1, 50, 0);   ready_is({tag, ".c5"}, 0);
        tick();                    out_is({tag, ".c6"}, 1, 500, 0);  ready_is({tag, ".c6"}, 0);
        tick();                    out_is({tag, ".c7"}, 0, 0, 0);    ready_is({tag, ".c7"}, 1);
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reset state
        ready_is("rst", 1);
        out_is("rst", 0, 0, 0);
        chk("rst.dout_r", dout_r, rep_out(0));
        chk("rst.dout_i", dout_i, rep_out(0));
        ovf_is("rst", 0);

        // Single block with drain
        basic_block("blk");

        // Two back-to-back blocks, 8 continuous beats
        drive(1, 10, 5);  tick(); out_is("b2b.c1", 0, 0, 0);
        drive(1, 20, -5); tick(); out_is("b2b.c2", 0, 0, 0);
        drive(1, 1, 7);   tick(); out_is("b2b.c3", 1, 11, 12);
        drive(1, 2, 1);   tick(); out_is("b2b.c4", 1, 22, -4);
        drive(1, 30, 0);  tick(); out_is("b2b.c5", 1, 9, -2);   ready_is("b2b.c5", 1);
        drive(1, 40, 0);  tick(); out_is("b2b.c6", 1, 18, -6);  ready_is("b2b.c6", 1);
        drive(1, 3, 0);   tick(); out_is("b2b.c7", 1, 33, 0);
        drive(1, 4, 0);   tick(); out_is("b2b.c8", 1, 44, 0);
        drive(0, 0, 0);   tick(); out_is("b2b.c9", 1, 27, 0);   ready_is("b2b.c9", 0);
        tick();                   out_is("b2b.c10", 1, 36, 0);  ready_is("b2b.c10", 0);
        tick();                   out_is("b2b.c11", 0, 0, 0);   ready_is("b2b.c11", 1);

        // Gap inside the b-half
        drive(1, 100, 0);  tick(); out_is("gap.c1", 0, 0, 0);
        drive(1, 200, 0);  tick(); out_is("gap.c2", 0, 0, 0);
        drive(1, 50, 0);   tick(); out_is("gap.c3", 1, 150, 0);
        drive(0, 0, 0);    tick(); out_is("gap.c4", 0, 0, 0);
        drive(1, -300, 0); tick(); out_is("gap.c5", 1, -100, 0);
        drive(0, 0, 0);    tick(); out_is("gap.c6", 1, 50, 0);
        tick();                    out_is("gap.c7", 1, 500, 0);
        tick();                    out_is("gap.c8", 0, 0, 0);   ready_is("gap.c8", 1);

        // Extremes: saturation or full precision depending on build
        drive(1, 2047, -2048); tick(); out_is("big.c1", 0, 0, 0);
        drive(1, 0, 0);        tick(); out_is("big.c2", 0, 0, 0);
        drive(1, 2047, -2048); tick(); out_is("big.c3", 1, BIG_R, BIG_I); ovf_is("big.c3", BIG_O[0]);
        drive(1, 0, 0);        tick(); out_is("big.c4", 1, 0, 0);
        drive(0, 0, 0);        tick(); out_is("big.c5", 1, 0, 0);
        tick();                        out_is("big.c6", 1, 0, 0);
        tick();                        ovf_is("big.c7", BIG_O[0]);

        // Reset during drain cycle 1
        drive(1, 100, 0);  tick();
        drive(1, 200, 0);  tick();
        drive(1, 50, 0);   tick();
        drive(1, -300, 0); tick();
        drive(0, 0, 0);    tick(); out_is("rdr.c5", 1, 50, 0); ready_is("rdr.c5", 0);
        rstn = 1'b0;
        #1;
        ready_is("rdr.async", 1);
        out_is("rdr.async", 0, 0, 0);
        chk("rdr.async.dout_r", dout_r, rep_out(0));
        ovf_is("rdr.async", 0);
        tick();
        ready_is("rdr.c6", 1);
        out_is("rdr.c6", 0, 0, 0);
        rstn = 1'b1;
        tick();
        out_is("rdr.c7", 0, 0, 0);
        basic_block("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
